// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus of instr_fetch_ctrl: instruction-store address/data, decode
// handshake, redirect/trap requests and the r30 exception-pointer writeback.
interface instr_fetch_ctrl_if;
  logic [31:0] pc;
  logic [31:0] id_in;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_en;
  logic        redirect_jmp;
  logic [31:0] redirect_tgt;
  logic        illop;
  logic        irq;
  logic        xp_we;
  logic [31:0] xp_data;

  modport master (
    output pc, ir, ir_pc, ir_valid, xp_we, xp_data,
    input  id_in, ir_ready, redirect_en, redirect_jmp, redirect_tgt, illop, irq
  );

  modport slave (
    input  pc, ir, ir_pc, ir_valid, xp_we, xp_data,
    output id_in, ir_ready, redirect_en, redirect_jmp, redirect_tgt, illop, irq
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// PC sequencer / fetch controller: IR register, redirects, ILLOP and XADR traps.
// Optional macro PC_BOUNDS_CHECK_EN traps fetches beyond IMEM_WORDS as ILLOP.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC  = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC   = 32'h8000_0008,
  parameter int          IMEM_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic BOUNDS_CHECK = 1'b1;
`else
  localparam logic BOUNDS_CHECK = 1'b0;
`endif
  localparam logic [28:0] IMEM_LIM = 29'(IMEM_WORDS);

  state_t      state_r,    state_nxt_s;
  logic [31:0] pc_r,       pc_nxt_s;
  logic [31:0] ir_r,       ir_nxt_s;
  logic [31:0] ir_pc_r,    ir_pc_nxt_s;
  logic        ir_valid_r, ir_valid_nxt_s;
  logic        xp_we_r,    xp_we_nxt_s;
  logic [31:0] xp_data_r,  xp_data_nxt_s;

  logic        fetch_s;
  logic        illop_take_s;
  logic        fetch_fault_s;
  logic        irq_take_s;
  logic        redir_take_s;
  logic [31:0] pc_inc_s;
  logic [31:0] redir_pc_s;

  // Request qualification and candidate next-PC values
  always_comb begin
    fetch_s       = !ir_valid_r || bus.ir_ready;
    illop_take_s  = ir_valid_r && bus.illop;
    fetch_fault_s = BOUNDS_CHECK && fetch_s && (pc_r[30:2] >= IMEM_LIM);
    irq_take_s    = bus.irq && !pc_r[31];
    redir_take_s  = ir_valid_r && bus.redirect_en;
    pc_inc_s      = {pc_r[31], pc_r[30:0] + 31'd4};
    if (bus.redirect_jmp) begin
      // JMP may drop the supervisor bit but can never raise it
      redir_pc_s = {bus.redirect_tgt[31] & pc_r[31], bus.redirect_tgt[30:2], 2'b00};
    end else begin
      redir_pc_s = {pc_r[31], bus.redirect_tgt[30:2], 2'b00};
    end
  end

  // Next-state and next-register logic with illop > irq > redirect > fetch
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    ir_nxt_s       = ir_r;
    ir_pc_nxt_s    = ir_pc_r;
    ir_valid_nxt_s = ir_valid_r;
    xp_we_nxt_s    = 1'b0;
    xp_data_nxt_s  = xp_data_r;
    case (state_r)
      ST_RST: begin
        state_nxt_s    = ST_RUN;
        ir_valid_nxt_s = 1'b0;
      end
      ST_RUN: begin
        if (illop_take_s) begin
          state_nxt_s    = ST_TRAP;
          pc_nxt_s       = ILLOP_VEC;
          xp_data_nxt_s  = ir_pc_r + 32'd4;
          xp_we_nxt_s    = 1'b1;
          ir_valid_nxt_s = 1'b0;
        end else if (fetch_fault_s) begin
          state_nxt_s    = ST_TRAP;
          pc_nxt_s       = ILLOP_VEC;
          xp_data_nxt_s  = pc_r + 32'd4;
          xp_we_nxt_s    = 1'b1;
          ir_valid_nxt_s = 1'b0;
        end else if (irq_take_s) begin
          state_nxt_s    = ST_TRAP;
          pc_nxt_s       = XADR_VEC;
          xp_data_nxt_s  = ir_pc_r + 32'd4;
          xp_we_nxt_s    = 1'b1;
          ir_valid_nxt_s = 1'b0;
        end else if (redir_take_s) begin
          pc_nxt_s       = redir_pc_s;
          ir_valid_nxt_s = 1'b0;
        end else if (fetch_s) begin
          ir_nxt_s       = bus.id_in;
          ir_pc_nxt_s    = pc_r;
          ir_valid_nxt_s = 1'b1;
          pc_nxt_s       = pc_inc_s;
        end else begin
          pc_nxt_s       = pc_r;
          ir_valid_nxt_s = ir_valid_r;
        end
      end
      ST_TRAP: begin
        // xp_we was raised on entry; it drops as the trap completes
        state_nxt_s    = ST_RUN;
        ir_valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s    = ST_RST;
        pc_nxt_s       = RESET_VEC;
        ir_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RST;
      pc_r       <= RESET_VEC;
      ir_r       <= 32'd0;
      ir_pc_r    <= 32'd0;
      ir_valid_r <= 1'b0;
      xp_we_r    <= 1'b0;
      xp_data_r  <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      ir_r       <= ir_nxt_s;
      ir_pc_r    <= ir_pc_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
      xp_we_r    <= xp_we_nxt_s;
      xp_data_r  <= xp_data_nxt_s;
    end
  end

  assign bus.pc       = pc_r;
  assign bus.ir       = ir_r;
  assign bus.ir_pc    = ir_pc_r;
  assign bus.ir_valid = ir_valid_r;
  assign bus.xp_we    = xp_we_r;
  assign bus.xp_data  = xp_data_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed, table-driven bench for instr_fetch_ctrl with a 128-word ROM model.
module tb_instr_fetch_ctrl;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        ren;
    logic        rjmp;
    logic [31:0] tgt;
    logic        ill;
    logic        irq;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_ir_pc;
    logic        e_v;
    logic        e_we;
    logic [31:0] e_xd;
    logic        chk_ir;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vt[32];

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word at index i holds C0DE_0000 + i; index wraps modulo 128 words
  assign bus.id_in = 32'hC0DE_0000 | {25'd0, bus.pc[8:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rdy, input logic ren,
                              input logic rjmp, input logic [31:0] tgt,
                              input logic ill, input logic irq,
                              input logic [31:0] pc, input logic [31:0] ir,
                              input logic [31:0] irpc, input logic v,
                              input logic we, input logic [31:0] xd,
                              input logic ci);
    vec_t t;
    t.rst_n = r;  t.ready = rdy; t.ren = ren; t.rjmp = rjmp; t.tgt = tgt;
    t.ill = ill;  t.irq = irq;   t.e_pc = pc; t.e_ir = ir;   t.e_ir_pc = irpc;
    t.e_v = v;    t.e_we = we;   t.e_xd = xd; t.chk_ir = ci;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic ren,
                       input logic rjmp, input logic [31:0] tgt,
                       input logic ill, input logic irq);
    rst_n            = r;
    bus.ir_ready     = rdy;
    bus.redirect_en  = ren;
    bus.redirect_jmp = rjmp;
    bus.redirect_tgt = tgt;
    bus.illop        = ill;
    bus.irq          = irq;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // reset, release, stream, 3-cycle stall
    vt[0]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0000,32'h0,32'h0,1'b0,1'b0,32'h0,1'b1);
    vt[1]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0000,32'h0,32'h0,1'b0,1'b0,32'h0,1'b1);
    vt[2]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0004,32'hC0DE_0000,32'h8000_0000,1'b1,1'b0,32'h0,1'b1);
    vt[3]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'hC0DE_0001,32'h8000_0004,1'b1,1'b0,32'h0,1'b1);
    vt[4]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'hC0DE_0001,32'h8000_0004,1'b1,1'b0,32'h0,1'b1);
    vt[5]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'hC0DE_0001,32'h8000_0004,1'b1,1'b0,32'h0,1'b1);
    vt[6]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'hC0DE_0001,32'h8000_0004,1'b1,1'b0,32'h0,1'b1);
    vt[7]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_000C,32'hC0DE_0002,32'h8000_0008,1'b1,1'b0,32'h0,1'b1);
    vt[8]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0010,32'hC0DE_0003,32'h8000_000C,1'b1,1'b0,32'h0,1'b1);
    // branch in supervisor, JMP to user, irq trap
    vt[9]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0000_0051,1'b0,1'b0, 32'h8000_0050,32'h0,32'h0,1'b0,1'b0,32'h0,1'b0);
    vt[10] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0054,32'hC0DE_0014,32'h8000_0050,1'b1,1'b0,32'h0,1'b1);
    vt[11] = mk(1'b1,1'b1,1'b1,1'b1,32'h0000_0078,1'b0,1'b0, 32'h0000_0078,32'h0,32'h0,1'b0,1'b0,32'h0,1'b0);
    vt[12] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h0000_007C,32'hC0DE_001E,32'h0000_0078,1'b1,1'b0,32'h0,1'b1);
    vt[13] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1, 32'h8000_0008,32'h0,32'h0,1'b0,1'b1,32'h0000_007C,1'b0);
    vt[14] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'h0,32'h0,1'b0,1'b0,32'h0000_007C,1'b0);
    vt[15] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_000C,32'hC0DE_0002,32'h8000_0008,1'b1,1'b0,32'h0000_007C,1'b1);
    // illop + irq + redirect together: illop wins
    vt[16] = mk(1'b1,1'b1,1'b1,1'b0,32'h0000_0051,1'b1,1'b1, 32'h8000_0004,32'h0,32'h0,1'b0,1'b1,32'h8000_000C,1'b0);
    vt[17] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0004,32'h0,32'h0,1'b0,1'b0,32'h8000_000C,1'b0);
    vt[18] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'hC0DE_0001,32'h8000_0004,1'b1,1'b0,32'h8000_000C,1'b1);
    // irq ignored in supervisor mode
    vt[19] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1, 32'h8000_000C,32'hC0DE_0002,32'h8000_0008,1'b1,1'b0,32'h8000_000C,1'b1);
    // JMP taken while decode stalls
    vt[20] = mk(1'b1,1'b0,1'b1,1'b1,32'h0000_0040,1'b0,1'b0, 32'h0000_0040,32'h0,32'h0,1'b0,1'b0,32'h8000_000C,1'b0);
    vt[21] = mk(1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h0000_0044,32'hC0DE_0010,32'h0000_0040,1'b1,1'b0,32'h8000_000C,1'b1);
    // user irq beats branch
    vt[22] = mk(1'b1,1'b1,1'b1,1'b0,32'h0000_0100,1'b0,1'b1, 32'h8000_0008,32'h0,32'h0,1'b0,1'b1,32'h0000_0044,1'b0);
    vt[23] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0008,32'h0,32'h0,1'b0,1'b0,32'h0000_0044,1'b0);
    // illop without ir_valid is ignored
    vt[24] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1,1'b0, 32'h8000_000C,32'hC0DE_0002,32'h8000_0008,1'b1,1'b0,32'h0000_0044,1'b1);
    vt[25] = mk(1'b1,1'b1,1'b1,1'b1,32'h0000_0020,1'b0,1'b0, 32'h0000_0020,32'h0,32'h0,1'b0,1'b0,32'h0000_0044,1'b0);
    // unqualified redirect ignored, then user JMP cannot raise bit 31
    vt[26] = mk(1'b1,1'b1,1'b1,1'b1,32'h8000_0031,1'b0,1'b0, 32'h0000_0024,32'hC0DE_0008,32'h0000_0020,1'b1,1'b0,32'h0000_0044,1'b1);
    vt[27] = mk(1'b1,1'b1,1'b1,1'b1,32'h8000_0031,1'b0,1'b0, 32'h0000_0030,32'h0,32'h0,1'b0,1'b0,32'h0000_0044,1'b0);
    vt[28] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h0000_0034,32'hC0DE_000C,32'h0000_0030,1'b1,1'b0,32'h0000_0044,1'b1);
    // illop trap aborted by reset
    vt[29] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1,1'b0, 32'h8000_0004,32'h0,32'h0,1'b0,1'b1,32'h0000_0034,1'b0);
    vt[30] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0000,32'h0,32'h0,1'b0,1'b0,32'h0,1'b1);
    vt[31] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0, 32'h8000_0000,32'h0,32'h0,1'b0,1'b0,32'h0,1'b1);

    for (int i = 0; i < 32; i++) begin
      drive(vt[i].rst_n, vt[i].ready, vt[i].ren, vt[i].rjmp, vt[i].tgt, vt[i].ill, vt[i].irq);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), bus.pc, vt[i].e_pc);
      chk($sformatf("v%0d_ir_valid", i), {31'd0, bus.ir_valid}, {31'd0, vt[i].e_v});
      chk($sformatf("v%0d_xp_we", i), {31'd0, bus.xp_we}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d_xp_data", i), bus.xp_data, vt[i].e_xd);
      if (vt[i].chk_ir) begin
        chk($sformatf("v%0d_ir", i), bus.ir, vt[i].e_ir);
        chk($sformatf("v%0d_ir_pc", i), bus.ir_pc, vt[i].e_ir_pc);
      end else begin
        checks = checks;
      end
    end

    // Out-of-range user fetch at 0x200
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("oob_pre_pc", bus.pc, 32'h8000_0004);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("oob_jmp_pc", bus.pc, 32'h0000_0200);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
`ifdef PC_BOUNDS_CHECK_EN
    chk("oob_trap_pc", bus.pc, 32'h8000_0004);
    chk("oob_trap_we", {31'd0, bus.xp_we}, 32'd1);
    chk("oob_trap_xd", bus.xp_data, 32'h0000_0204);
    chk("oob_trap_v", {31'd0, bus.ir_valid}, 32'd0);
    @(posedge clk); #1;
    chk("oob_we_drop", {31'd0, bus.xp_we}, 32'd0);
`else
    chk("wrap_pc", bus.pc, 32'h0000_0204);
    chk("wrap_ir", bus.ir, 32'hC0DE_0000);
    chk("wrap_ir_pc", bus.ir_pc, 32'h0000_0200);
    chk("wrap_we", {31'd0, bus.xp_we}, 32'd0);
    @(posedge clk); #1;
    chk("wrap_next_ir", bus.ir, 32'hC0DE_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
